apb_wait_slave: RTL



---
 rtl/apb_pkg.sv | 11 +
 rtl/apb_regfile.sv | 38 +++
 rtl/apb_wait_slave.sv | 126 ++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB wait-state slave and its register file.
package apb_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, READY} apb_state_t;

    localparam int unsigned APB_ADDR_W = 5;
    localparam int unsigned APB_DATA_W = 32;
    // Wide enough for the largest supported wait count (15).
    localparam int unsigned CNT_W      = $clog2(16);

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x DATA_W register array: synchronous write and clear, combinational read.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int unsigned DATA_W = APB_DATA_W,
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DEPTH  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Unimplemented addresses read as zero rather than X.
    always_comb begin
        rdata = '0;
        if (32'(raddr) < DEPTH) begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/apb_wait_slave.sv
// APB register-file responder with programmable wait states and pslverr on unmapped
// addresses; pready, pslverr and prdata are registered and nonzero only in READY.
module apb_wait_slave
    import apb_pkg::*;
#(
    parameter int unsigned DATA_W      = APB_DATA_W,
    parameter int unsigned ADDR_W      = APB_ADDR_W,
    parameter int unsigned DEPTH       = 24,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    apb_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              pwrite_q;
    logic              err_q;

    logic              addr_err;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] rd_val;
    logic              rd_err;
    logic              rd_write;
    logic              we;

    // With zero wait states READY is entered straight from the setup edge, so the
    // read path must look at the live bus instead of the latched copy.
    always_comb begin
        addr_err = (32'(addr) >= DEPTH);
        raddr    = addr_q;
        rd_err   = err_q;
        rd_write = pwrite_q;
        if (state_q == IDLE) begin
            raddr    = addr;
            rd_err   = addr_err;
            rd_write = pwrite;
        end
        rd_val = (rd_err || rd_write) ? '0 : rdata;
        we     = (state_q == READY) && psel && pwrite_q && !err_q;
    end

    apb_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (addr_q),
        .wdata (pwdata_q),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            err_q    <= 1'b0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            prdata   <= '0;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            unique case (state_q)
                IDLE: begin
                    if (psel && !penable) begin
                        addr_q   <= addr;
                        pwdata_q <= pwdata;
                        pwrite_q <= pwrite;
                        err_q    <= addr_err;
                        cnt_q    <= '0;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= READY;
                            pready  <= 1'b1;
                            pslverr <= addr_err;
                            prdata  <= rd_val;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        state_q <= IDLE;
                    end else if (penable) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            state_q <= READY;
                            pready  <= 1'b1;
                            pslverr <= err_q;
                            prdata  <= rd_val;
                        end
                    end
                end
                READY: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
